// File: rtl/ysyx_041514_pipe_ctrl.sv
// Pipeline hazard controller: per-register stall/flush generation, PC redirect
// arbitration with a pending-target FSM for busy fetch, and a front-end stall counter.
module ysyx_041514_pipe_ctrl (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_if_stall_i,
   input  logic        req_id_hazard_i,
   input  logic        req_ex_busy_i,
   input  logic        req_mem_busy_i,
   input  logic        branch_valid_i,
   input  logic [63:0] branch_pc_i,
   input  logic        trap_valid_i,
   input  logic [63:0] trap_pc_i,
   input  logic        fetch_busy_i,
   input  logic        perf_clr_i,
   output logic [5:0]  stall_valid_o,
   output logic [5:0]  flush_valid_o,
   output logic        redirect_valid_o,
   output logic [63:0] redirect_pc_o,
   output logic [31:0] stall_cycles_o
);

   typedef enum logic {IDLE, PEND} state_e;

   state_e      state_q;
   logic [63:0] tgt_q;
   logic [31:0] stall_cnt_q;

   logic        trap_take;
   logic        branch_take;
   logic        redir_take;
   logic [63:0] redir_tgt;
   logic [5:0]  stall_d;
   logic [5:0]  flush_d;
   logic        redir_valid_d;
   logic [63:0] redir_pc_d;

   assign trap_take   = trap_valid_i & ~req_mem_busy_i;
   assign branch_take = branch_valid_i & ~trap_take & ~req_mem_busy_i & ~req_ex_busy_i
                        & (state_q == IDLE);
   assign redir_take  = trap_take | branch_take;
   assign redir_tgt   = trap_take ? trap_pc_i : branch_pc_i;

   // NOTE: every always_comb output gets a default first so no path can infer a latch.
   always_comb begin
      stall_d       = 6'b000000;
      flush_d       = 6'b000000;
      redir_valid_d = 1'b0;
      redir_pc_d    = tgt_q;

      if (req_mem_busy_i) begin
         stall_d = 6'b001111;
         flush_d = 6'b010000;
      end else if (req_ex_busy_i) begin
         stall_d = 6'b000111;
         flush_d = 6'b001000;
      end else if (req_id_hazard_i) begin
         stall_d = 6'b000011;
         flush_d = 6'b000100;
      end else if (req_if_stall_i) begin
         stall_d = 6'b000001;
         flush_d = 6'b000010;
      end

      // While a redirect waits for fetch, hold PC and keep bubbling IF_ID.
      if (state_q == PEND) begin
         stall_d = stall_d | 6'b000001;
         flush_d = flush_d | 6'b000010;
      end

      if (trap_take)   flush_d = flush_d | 6'b001110;
      if (branch_take) flush_d = flush_d | 6'b000110;

      stall_d = stall_d & ~flush_d;

      if (!fetch_busy_i) begin
         if (state_q == IDLE && redir_take) begin
            redir_valid_d = 1'b1;
            redir_pc_d    = redir_tgt;
         end else if (state_q == PEND) begin
            redir_valid_d = 1'b1;
            redir_pc_d    = trap_take ? trap_pc_i : tgt_q;
         end
      end

      // Reset must clear the combinational outputs too, not just the registers.
      if (!rst) begin
         stall_d       = 6'b000000;
         flush_d       = 6'b000000;
         redir_valid_d = 1'b0;
         redir_pc_d    = 64'd0;
      end
   end

   assign stall_valid_o    = stall_d;
   assign flush_valid_o    = flush_d;
   assign redirect_valid_o = redir_valid_d;
   assign redirect_pc_o    = redir_pc_d;
   assign stall_cycles_o   = stall_cnt_q;

   // NOTE: sequential state uses non-blocking assignments so all flops update together.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         tgt_q   <= 64'd0;
      end else begin
         case (state_q)
            IDLE: begin
               if (redir_take && fetch_busy_i) begin
                  tgt_q   <= redir_tgt;
                  state_q <= PEND;
               end
            end
            PEND: begin
               if (trap_take) tgt_q <= trap_pc_i;
               if (!fetch_busy_i) state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         stall_cnt_q <= 32'd0;
      end else if (perf_clr_i) begin
         stall_cnt_q <= 32'd0;
      end else if (stall_d[0] && stall_cnt_q != 32'hFFFF_FFFF) begin
         stall_cnt_q <= stall_cnt_q + 32'd1;
      end
   end

endmodule
